// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit adder slice and a registered carry,
// LSB digit first, with a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNTW  = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_badParam
            $error("serial_adder: DIGIT must lie in 1..WIDTH and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_aMsb;
    logic             r_bMsb;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT:0]   w_digitSum;
    logic [WIDTH-1:0] w_accNext;
    logic             w_lastStep;

    assign w_digitSum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    // Each new digit enters at the MSB end, so after STEPS shifts the LSB digit sits at bit 0.
    assign w_accNext  = (r_acc >> DIGIT) | (WIDTH'(w_digitSum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign w_lastStep = (r_cnt == CNTW'(STEPS - 1));

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_lastStep) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1; the operand MSBs are kept because the shift registers lose them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_aMsb  <= 1'b0;
            r_bMsb  <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub | i_cin;
                        r_aMsb  <= i_a[WIDTH-1];
                        r_bMsb  <= i_sub ? ~i_b[WIDTH-1] : i_b[WIDTH-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_accNext;
                    r_carry <= w_digitSum[DIGIT];
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_lastStep) begin
                        r_sum  <= w_accNext;
                        r_cout <= w_digitSum[DIGIT];
                        r_ovf  <= (r_aMsb == r_bMsb) && (w_accNext[WIDTH-1] != r_aMsb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three serial_adder instances (DIGIT 4, 1, 16) checked against
// a plain-arithmetic reference model, with directed and random operations.
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [15:0] sum [3];

    int          compareCount;
    int          mismatchCount;
    int          steps [3];
    logic [15:0] heldSum [3];

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(busy[0]), .o_done(done[0]), .o_sum(sum[0]), .o_cout(cout[0]), .o_ovf(ovf[0]));
    serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(busy[1]), .o_done(done[1]), .o_sum(sum[1]), .o_cout(cout[1]), .o_ovf(ovf[1]));
    serial_adder #(.WIDTH(16), .DIGIT(16)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(busy[2]), .o_done(done[2]), .o_sum(sum[2]), .o_cout(cout[2]), .o_ovf(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: ordinary integer arithmetic, overflow judged against the signed 16-bit range.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin, input logic msub,
                         output logic [15:0] s, output logic c, output logic o);
        int sa;
        int sb;
        int r;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            s = ma - mb;
            c = (ma >= mb);
            r = sa - sb;
        end else begin
            s = ma + mb + {15'd0, mcin};
            c = (int'(ma) + int'(mb) + int'(mcin)) > 65535;
            r = sa + sb + int'(mcin);
        end
        o = (r > 32767) || (r < -32768);
    endtask

    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                                 input logic tsub, input logic [2:0] mask);
        logic [15:0] es;
        logic        ec;
        logic        eo;
        model(ta, tb, tcin, tsub, es, ec, eo);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; start = mask;
        @(posedge clk);
        #1;
        start = 3'b000;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int d = 0; d < 3; d++) begin
            if (mask[d]) checkOutput($sformatf("d%0d_busy_accept", d), {31'd0, busy[d]}, 32'd1);
        end
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (mask[d]) begin
                    checkOutput($sformatf("d%0d_busy_c%0d", d, cyc), {31'd0, busy[d]}, {31'd0, cyc < steps[d]});
                    checkOutput($sformatf("d%0d_done_c%0d", d, cyc), {31'd0, done[d]}, {31'd0, cyc == steps[d]});
                    if (cyc == steps[d]) begin
                        heldSum[d] = es;
                        checkOutput($sformatf("d%0d_cout", d), {31'd0, cout[d]}, {31'd0, ec});
                        checkOutput($sformatf("d%0d_ovf", d), {31'd0, ovf[d]}, {31'd0, eo});
                    end
                    checkOutput($sformatf("d%0d_sum_c%0d", d, cyc), {16'd0, sum[d]}, {16'd0, heldSum[d]});
                end
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s_d%0d_flags", tag, d),
                        {28'd0, busy[d], done[d], cout[d], ovf[d]}, 32'd0);
            checkOutput($sformatf("%s_d%0d_sum", tag, d), {16'd0, sum[d]}, 32'd0);
        end
    endtask

    task automatic backToBack();
        logic [15:0] qs [$];
        logic        qc [$];
        logic        qo [$];
        logic [15:0] es;
        logic        ec;
        logic        eo;
        @(negedge clk);
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        start = 3'b001;
        for (int e = 0; e < 24; e++) begin
            @(posedge clk);
            if (e % 6 == 0) begin
                model(a, b, cin, sub, es, ec, eo);
                qs.push_back(es); qc.push_back(ec); qo.push_back(eo);
            end
            #1;
            if (e == 23) start = 3'b000;
            checkOutput($sformatf("b2b_busy_e%0d", e), {31'd0, busy[0]}, {31'd0, (e % 6) < 4});
            checkOutput($sformatf("b2b_done_e%0d", e), {31'd0, done[0]}, {31'd0, (e % 6) == 4});
            if (e % 6 == 4 && qs.size() > 0) begin
                heldSum[0] = qs.pop_front();
                checkOutput($sformatf("b2b_cout_e%0d", e), {31'd0, cout[0]}, {31'd0, qc.pop_front()});
                checkOutput($sformatf("b2b_ovf_e%0d", e), {31'd0, ovf[0]}, {31'd0, qo.pop_front()});
            end
            checkOutput($sformatf("b2b_sum_e%0d", e), {16'd0, sum[0]}, {16'd0, heldSum[0]});
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end
        checkOutput("b2b_queue_empty", qs.size(), 32'd0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        steps[0] = 4; steps[1] = 16; steps[2] = 1;
        for (int d = 0; d < 3; d++) heldSum[d] = 16'h0000;
        rst_n = 1'b0; start = 3'b000; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #23;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(16'h1234, 16'h0FFF, 1'b1, 1'b0, 3'b111);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b111);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'b111);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 3'b111);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 3'b111);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b1, 3'b111);

        $display("[TB] random operations");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 3'b111);
        end

        $display("[TB] start held high");
        backToBack();

        $display("[TB] reset during run");
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 3'b111);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 3'b011;
        @(posedge clk);
        #1;
        start = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("midrun_reset");
        for (int d = 0; d < 3; d++) heldSum[d] = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post_reset_idle_%0d", i), {29'd0, busy}, 32'd0);
            checkOutput($sformatf("post_reset_nodone_%0d", i), {29'd0, done}, 32'd0);
        end
        applyStimulus(16'h1234, 16'h0FFF, 1'b1, 1'b0, 3'b111);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
